// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer.
// State encoding and prescaler width helper.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      DONE
   } state_t;

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/countdown_n_tick_gen.sv
// Prescaler for the countdown timer.
// Emits one tick every DIV enabled clocks.
module tick_gen
   import countdown_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = clog2_min1(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // prescaler: clear wins, hold when not enabled, wrap on tick
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/countdown_n.sv
// Loadable down-counter with start/pause/abort/re-arm.
// Holds the FSM, count, reload value and done pulse.
module countdown_n
   import countdown_pkg::*;
#(
   parameter int N   = 6,
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         start,
   input  logic         pause,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         zero,
   output logic         done,
   output state_t       state
);

   localparam logic [N-1:0] ONE = N'(1);

   state_t       state_n;
   logic [N-1:0] q_n;
   logic [N-1:0] rld;
   logic [N-1:0] rld_n;
   logic         done_n;
   logic         tick;
   logic         en;
   logic         clr;

   assign busy = (state == RUN);
   assign zero = (q == '0);

   // prescaler advances only while running and not leaving RUN
   assign en  = busy && !load && !(pause && !start);
   assign clr = (state == IDLE) || (state == DONE);

   tick_gen #(
      .DIV(DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (clr),
      .tick(tick)
   );

   // state, count, reload and done registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         rld   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         q     <= q_n;
         rld   <= rld_n;
         done  <= done_n;
      end
   end

   // next-state: load > start > pause
   always_comb begin
      state_n = state;
      q_n     = q;
      rld_n   = rld;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (load) begin
               q_n   = d;
               rld_n = d;
            end else if (start && q != '0) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (load) begin
               q_n     = d;
               rld_n   = d;
               state_n = IDLE;
            end else if (pause && !start) begin
               state_n = PAUSED;
            end else if (tick) begin
               if (q > ONE) begin
                  q_n = q - ONE;
               end else begin
                  q_n     = '0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end
            end
         end
         PAUSED: begin
            if (load) begin
               q_n     = d;
               rld_n   = d;
               state_n = IDLE;
            end else if (start) begin
               state_n = RUN;
            end
         end
         DONE: begin
            if (load) begin
               q_n     = d;
               rld_n   = d;
               state_n = IDLE;
            end else if (start) begin
               q_n = rld;
               if (rld != '0) begin
                  state_n = RUN;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   a_done: assert property (@(posedge clk) disable iff (rst)
      done |-> (state == DONE && q == '0));

   a_busy: assert property (@(posedge clk)
      busy == (state == RUN));

endmodule

// File: tb/tb_countdown_n.sv
// Directed bench for countdown_n (N=4, DIV=3 and DIV=1).
// Linear steps with immediate assertions.
module tb_countdown_n;
   import countdown_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       load, start, pause;
   logic [3:0] d;
   logic [3:0] q;
   logic       busy, zero, done;
   state_t     state;

   logic       load1, start1, pause1;
   logic [3:0] d1;
   logic [3:0] q1;
   logic       busy1, zero1, done1;
   state_t     state1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   countdown_n #(.N(4), .DIV(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .start(start),
      .pause(pause),
      .d    (d),
      .q    (q),
      .busy (busy),
      .zero (zero),
      .done (done),
      .state(state)
   );

   countdown_n #(.N(4), .DIV(1)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .load (load1),
      .start(start1),
      .pause(pause1),
      .d    (d1),
      .q    (q1),
      .busy (busy1),
      .zero (zero1),
      .done (done1),
      .state(state1)
   );

   task automatic tk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input state_t s);
      chk(tag, 32'(state), 32'(s));
   endtask

   initial begin
      rst = 1'b1; load = 0; start = 0; pause = 0; d = 0;
      load1 = 0; start1 = 0; pause1 = 0; d1 = 0;
      tk(2);
      rst = 1'b0;
      chk("rst_q", q, 0);
      st("rst_state", IDLE);
      chk("rst_busy", busy, 0);
      chk("rst_zero", zero, 1);
      chk("rst_done", done, 0);

      // 1: load 3, run to zero
      load = 1; d = 3; tk(1); load = 0;
      chk("t1_load_q", q, 3);
      st("t1_load_st", IDLE);
      start = 1; tk(1); start = 0;
      st("t1_run", RUN);
      chk("t1_busy", busy, 1);
      tk(2); chk("t1_q3", q, 3);
      tk(1); chk("t1_q2", q, 2);
      tk(2); chk("t1_q2b", q, 2);
      tk(1); chk("t1_q1", q, 1);
      chk("t1_nodone", done, 0);
      tk(3); chk("t1_q0", q, 0);
      chk("t1_done", done, 1);
      st("t1_st_done", DONE);
      chk("t1_busy0", busy, 0);
      tk(1); chk("t1_done_off", done, 0);
      st("t1_st_hold", DONE);

      // 2: run from 5, pause with prescaler at 1
      load = 1; d = 5; tk(1); load = 0;
      start = 1; tk(1); start = 0;
      tk(3); chk("t2_q4", q, 4);
      tk(1);
      pause = 1; tk(1); pause = 0;
      st("t2_paused", PAUSED);
      tk(10);
      chk("t2_hold_q", q, 4);
      st("t2_hold_st", PAUSED);
      start = 1; tk(1); start = 0;
      st("t2_resume", RUN);
      tk(1); chk("t2_pre_dec", q, 4);
      tk(1); chk("t2_dec", q, 3);
      tk(9); chk("t2_q0", q, 0);
      chk("t2_done", done, 1);

      // 3: re-arm from DONE
      tk(1);
      start = 1; tk(1); start = 0;
      chk("t3_reload", q, 5);
      st("t3_run", RUN);
      tk(14); chk("t3_q1", q, 1);
      chk("t3_nodone", done, 0);
      tk(1); chk("t3_q0", q, 0);
      chk("t3_done", done, 1);
      tk(1); chk("t3_done_off", done, 0);

      // 4: zero load then start is ignored
      load = 1; d = 0; tk(1); load = 0;
      start = 1; tk(1); start = 0;
      st("t4_idle", IDLE);
      chk("t4_q", q, 0);
      tk(3); chk("t4_nodone", done, 0);

      // 5: load+start while running aborts
      load = 1; d = 6; tk(1); load = 0;
      start = 1; tk(1); start = 0;
      tk(3); chk("t5_q5", q, 5);
      load = 1; start = 1; d = 7; tk(1); load = 0; start = 0;
      chk("t5_q7", q, 7);
      st("t5_idle", IDLE);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      tk(4); chk("t5_stay", q, 7);

      // 6: reset mid-run at q=2
      start = 1; tk(1); start = 0;
      tk(15); chk("t6_q2", q, 2);
      rst = 1; tk(1); rst = 0;
      chk("t6_q0", q, 0);
      st("t6_idle", IDLE);
      chk("t6_zero", zero, 1);
      start = 1; tk(1); start = 0;
      st("t6_ignored", IDLE);
      tk(4); chk("t6_nodone", done, 0);
      chk("t6_q_hold", q, 0);

      // DIV=1, d=1
      load1 = 1; d1 = 1; tk(1); load1 = 0;
      start1 = 1; tk(1); start1 = 0;
      chk("d1_run", 32'(state1), 32'(RUN));
      chk("d1_q1", q1, 1);
      tk(1); chk("d1_q0", q1, 0);
      chk("d1_done", done1, 1);
      chk("d1_st", 32'(state1), 32'(DONE));
      tk(1); chk("d1_done_off", done1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
